chimera_cluster_pwr_ctrl: RTL and testbench
===========================================

// Module: chimera_cluster_pwr_ctrl
// PURPOSE
// Register-bus responder for the top-level control region (base 0x3000_1000, 4 KiB) of the Chimera SoC.
// Answers Cheshire reg-bus requests and holds per-cluster enable and boot-address registers.
// Runs one power-sequencing FSM per external cluster that drives that cluster's clock gate, reset and AXI isolation.
// Sits between the Cheshire external reg demux port and the cluster wrappers.
// PARAMETERS
// NumClusters      5             external clusters, 1..16
// SettleCycles     4             cycles spent in each timed FSM state, >=1
// BootAddrDefault  32'h3000_0000 reset value of every BOOT_ADDR register
// AddrWidth        32            reg-bus address width
// PORTS
// clk_i              in   1              single clock
// rst_i              in   1              synchronous reset, active-high
// reg_valid_i        in   1              request valid; held with all request fields stable until reg_ready_o
// reg_write_i        in   1              1 = write, 0 = read
// reg_addr_i         in   AddrWidth      byte address; only [11:0] decoded
// reg_wdata_i        in   32             write data
// reg_wstrb_i        in   4              byte strobes
// reg_ready_o        out  1              response valid; completes the handshake
// reg_rdata_o        out  32             read data; 0 on error or write
// reg_error_o        out  1              slave error
// cluster_idle_i     in   NumClusters    cluster has no outstanding traffic
// cluster_clk_en_o   out  NumClusters    clock-gate enable
// cluster_rst_no     out  NumClusters    cluster reset, active-low
// cluster_iso_o      out  NumClusters    AXI isolation request
// cluster_boot_addr_o out 32*NumClusters BOOT_ADDR[i] at bits [32i+:32]
// BEHAVIOUR
// Reset values:
// - ready/rdata/error = 0; EN = 0; BOOT_ADDR = BootAddrDefault.
// - All FSMs in OFF: clk_en = 0, rst_n = 0, iso = 1.
// Handshake:
// - Rule: ready_q <= valid_i & ~ready_q.
// - Request sampled at cycle t → ready = 1 in cycle t+1 only.
// - Earliest next acceptance is t+2 → ready = 1 in t+3.
// - rdata/error are registered at end of t from state in t.
// - Writes commit at the end of t and are visible from t+1.
// Address map (addr[11:0]); any other offset or addr[1:0] != 0 gives error = 1 with no side effect:
// - 0x000 EN, RW: bits [NumClusters-1:0] hold the enable requests; other bits read 0.
// - 0x004 STATUS, RO: [i] = FSM_i in ON; [16+i] = FSM_i busy (not OFF and not ON); a write returns error.
// - 0x010 + 4*i BOOT_ADDR_i, RW: for i < NumClusters, the byte lanes given by wstrb are written.
// - EN is also byte-strobed. wstrb = 0 on a write: no effect, no error.
// FSM_i states and outputs (clk_en / rst_n / iso):
// - OFF = 0/0/1; CLK_ON = 1/0/1; RST_REL = 1/1/1; ON = 1/1/0; DRAIN = 1/1/1; RST_ASSERT = 1/0/1.
// - Outputs are registered decodes of the state.
// FSM_i transitions:
// - OFF: EN[i] → CLK_ON.
// - CLK_ON: after SettleCycles → RST_REL; if ~EN[i] → RST_ASSERT.
// - RST_REL: after SettleCycles → ON; if ~EN[i] → DRAIN.
// - ON: ~EN[i] → DRAIN.
// - DRAIN: EN[i] → ON (abort); else idle_i[i] → RST_ASSERT. Waits in DRAIN with no timeout.
// - RST_ASSERT: after SettleCycles → OFF, always; if EN[i] is then set, it re-powers from OFF.
// Timing and counters:
// - A timed state is occupied exactly SettleCycles cycles; its counter clears on state entry.
// - An EN change takes priority over timer expiry in the same cycle.
// - The FSM sees committed EN one cycle after commit.
// - FSMs are independent; simultaneous EN changes on many clusters are allowed.
// - BOOT_ADDR can be written in any state; outputs follow the register directly.
// Reset:
// - rst_i mid-sequence returns every FSM to OFF in the next cycle.
// - rst_i mid-handshake drops ready; the master must reissue.
// TESTING (NumClusters=5, SettleCycles=4)
// - Write 0x000=0x01 at cycle t:
//   - clk_en_o[0] = 1 from t+2, rst_no[0] = 1 from t+6, iso_o[0] = 0 from t+10.
//   - STATUS reads 0x0001_0000 mid-sequence and 0x0000_0001 after.
// - From ON, write EN=0 with idle_i[0] = 0 for 20 cycles:
//   - iso_o[0] = 1 and rst_no[0] = 1 hold while idle_i is low.
//   - Raise idle_i → rst_no[0] = 0 for 4 cycles, then clk_en_o[0] = 0.
// - In DRAIN, rewrite EN=1 → iso_o[0] = 0 next FSM cycle; rst_no[0] never drops.
// - Write 0x018 = 0xDEAD_BEEF, wstrb = 4'b0011 → boot_addr_o[2] = 0x3000_BEEF; readback matches.
// - Read 0x008; write 0x004; read 0x024; access 0x012 → each returns error = 1, rdata = 0, no state change.
// - Assert rst_i during RST_REL of cluster 3 → all outputs at reset values in the next cycle; EN reads 0.

Source files
------------

// File: rtl/chimera_cluster_pwr_ctrl.sv
// Chimera top-level control region: reg-bus responder with per-cluster EN/BOOT_ADDR registers
// and one power-sequencing FSM per cluster driving clock gate, reset and AXI isolation.
module chimera_cluster_pwr_ctrl #(
    parameter int unsigned NumClusters     = 5,
    parameter int unsigned SettleCycles    = 4,
    parameter logic [31:0] BootAddrDefault = 32'h3000_0000,
    parameter int unsigned AddrWidth       = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     reg_valid_i,
    input  logic                     reg_write_i,
    input  logic [AddrWidth-1:0]     reg_addr_i,
    input  logic [31:0]              reg_wdata_i,
    input  logic [3:0]               reg_wstrb_i,
    output logic                     reg_ready_o,
    output logic [31:0]              reg_rdata_o,
    output logic                     reg_error_o,
    input  logic [NumClusters-1:0]   cluster_idle_i,
    output logic [NumClusters-1:0]   cluster_clk_en_o,
    output logic [NumClusters-1:0]   cluster_rst_no,
    output logic [NumClusters-1:0]   cluster_iso_o,
    output logic [32*NumClusters-1:0] cluster_boot_addr_o
);

    localparam int unsigned CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

    typedef enum logic [2:0] {
        S_OFF,
        S_CLK_ON,
        S_RST_REL,
        S_ON,
        S_DRAIN,
        S_RST_ASSERT
    } state_e;

    logic                   r_ready;
    logic [31:0]            r_rdata;
    logic                   r_err;
    logic [NumClusters-1:0] r_en;
    logic [31:0]            r_boot [NumClusters];

    logic [11:0]            w_off;
    logic                   w_accept;
    logic                   w_hit_en;
    logic                   w_hit_st;
    logic [NumClusters-1:0] w_ba_sel;
    logic                   w_err;
    logic [31:0]            w_rdata;
    logic [31:0]            w_mask;
    logic [NumClusters-1:0] w_on;
    logic [NumClusters-1:0] w_busy;
    logic                   w_unused;

    assign w_off    = reg_addr_i[11:0];
    assign w_unused = ^reg_addr_i[AddrWidth-1:12];
    assign w_accept = reg_valid_i & ~r_ready;
    assign w_mask   = {{8{reg_wstrb_i[3]}}, {8{reg_wstrb_i[2]}},
                       {8{reg_wstrb_i[1]}}, {8{reg_wstrb_i[0]}}};

    // Misaligned offsets never match an aligned register, so they fall into the error path.
    always_comb begin
        w_hit_en = (w_off == 12'h000);
        w_hit_st = (w_off == 12'h004);
        w_ba_sel = '0;
        for (int i = 0; i < int'(NumClusters); i++) begin
            w_ba_sel[i] = (w_off == (12'h010 + 12'(4 * i)));
        end
        w_err = ~(w_hit_en | w_hit_st | (|w_ba_sel)) | (reg_write_i & w_hit_st);
    end

    always_comb begin
        w_rdata = '0;
        if (!reg_write_i && !w_err) begin
            if (w_hit_en) begin
                w_rdata[NumClusters-1:0] = r_en;
            end
            if (w_hit_st) begin
                w_rdata[NumClusters-1:0]      = w_on;
                w_rdata[16 +: NumClusters]    = w_busy;
            end
            for (int i = 0; i < int'(NumClusters); i++) begin
                if (w_ba_sel[i]) begin
                    w_rdata = r_boot[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_en    <= '0;
            for (int i = 0; i < int'(NumClusters); i++) begin
                r_boot[i] <= BootAddrDefault;
            end
        end else begin
            r_ready <= reg_valid_i & ~r_ready;
            if (w_accept) begin
                r_rdata <= w_rdata;
                r_err   <= w_err;
            end
            if (w_accept && reg_write_i && !w_err) begin
                if (w_hit_en) begin
                    r_en <= (r_en & ~w_mask[NumClusters-1:0])
                          | (reg_wdata_i[NumClusters-1:0] & w_mask[NumClusters-1:0]);
                end
                for (int i = 0; i < int'(NumClusters); i++) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_ba_sel[i] && reg_wstrb_i[b]) begin
                            r_boot[i][8*b +: 8] <= reg_wdata_i[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    assign reg_ready_o = r_ready;
    assign reg_rdata_o = r_rdata;
    assign reg_error_o = r_err;

    for (genvar g = 0; g < int'(NumClusters); g++) begin : g_cl
        state_e          r_state;
        state_e          w_nxt;
        logic [CntW-1:0] r_cnt;
        logic [CntW-1:0] w_cnt_nxt;
        logic            w_done;
        logic            r_clk_en;
        logic            r_rst_n;
        logic            r_iso;

        assign w_done = (r_cnt == CntW'(SettleCycles - 1));

        // EN changes are tested before timer expiry so they win in the same cycle.
        always_comb begin
            w_nxt     = r_state;
            w_cnt_nxt = '0;
            case (r_state)
                S_OFF: begin
                    if (r_en[g]) w_nxt = S_CLK_ON;
                end
                S_CLK_ON: begin
                    if (!r_en[g])    w_nxt = S_RST_ASSERT;
                    else if (w_done) w_nxt = S_RST_REL;
                    else             w_cnt_nxt = r_cnt + CntW'(1);
                end
                S_RST_REL: begin
                    if (!r_en[g])    w_nxt = S_DRAIN;
                    else if (w_done) w_nxt = S_ON;
                    else             w_cnt_nxt = r_cnt + CntW'(1);
                end
                S_ON: begin
                    if (!r_en[g]) w_nxt = S_DRAIN;
                end
                S_DRAIN: begin
                    if (r_en[g])                 w_nxt = S_ON;
                    else if (cluster_idle_i[g])  w_nxt = S_RST_ASSERT;
                end
                S_RST_ASSERT: begin
                    if (w_done) w_nxt = S_OFF;
                    else        w_cnt_nxt = r_cnt + CntW'(1);
                end
                default: w_nxt = S_OFF;
            endcase
        end

        // Outputs register the decode of the next state so they line up with the state itself.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_state  <= S_OFF;
                r_cnt    <= '0;
                r_clk_en <= 1'b0;
                r_rst_n  <= 1'b0;
                r_iso    <= 1'b1;
            end else begin
                r_state  <= w_nxt;
                r_cnt    <= w_cnt_nxt;
                r_clk_en <= (w_nxt != S_OFF);
                r_rst_n  <= (w_nxt == S_RST_REL) || (w_nxt == S_ON) || (w_nxt == S_DRAIN);
                r_iso    <= (w_nxt != S_ON);
            end
        end

        assign w_on[g]   = (r_state == S_ON);
        assign w_busy[g] = (r_state != S_ON) && (r_state != S_OFF);

        assign cluster_clk_en_o[g]         = r_clk_en;
        assign cluster_rst_no[g]           = r_rst_n;
        assign cluster_iso_o[g]            = r_iso;
        assign cluster_boot_addr_o[32*g +: 32] = r_boot[g];
    end

endmodule

// File: tb/tb_chimera_cluster_pwr_ctrl.sv
// Directed bench for chimera_cluster_pwr_ctrl: power sequencing, drain/abort, boot-address
// strobes, error decode and mid-sequence reset, with hand-computed expected values.
module tb_chimera_cluster_pwr_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        reg_valid_i;
    logic        reg_write_i;
    logic [31:0] reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic [3:0]  reg_wstrb_i;
    logic        reg_ready_o;
    logic [31:0] reg_rdata_o;
    logic        reg_error_o;
    logic [4:0]  cluster_idle_i;
    logic [4:0]  cluster_clk_en_o;
    logic [4:0]  cluster_rst_no;
    logic [4:0]  cluster_iso_o;
    logic [159:0] cluster_boot_addr_o;

    int n_total = 0;
    int n_bad   = 0;

    bit watch_rst = 1'b0;
    bit rst_dropped = 1'b0;

    chimera_cluster_pwr_ctrl #(
        .NumClusters    (5),
        .SettleCycles   (4),
        .BootAddrDefault(32'h3000_0000),
        .AddrWidth      (32)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .reg_valid_i        (reg_valid_i),
        .reg_write_i        (reg_write_i),
        .reg_addr_i         (reg_addr_i),
        .reg_wdata_i        (reg_wdata_i),
        .reg_wstrb_i        (reg_wstrb_i),
        .reg_ready_o        (reg_ready_o),
        .reg_rdata_o        (reg_rdata_o),
        .reg_error_o        (reg_error_o),
        .cluster_idle_i     (cluster_idle_i),
        .cluster_clk_en_o   (cluster_clk_en_o),
        .cluster_rst_no     (cluster_rst_no),
        .cluster_iso_o      (cluster_iso_o),
        .cluster_boot_addr_o(cluster_boot_addr_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (watch_rst && !cluster_rst_no[0]) rst_dropped = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Returns #1 after the edge that raises ready, i.e. in the cycle after the request was sampled.
    task automatic bus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata, output logic err);
        bit done = 1'b0;
        step(1);
        reg_valid_i = 1'b1;
        reg_write_i = wr;
        reg_addr_i  = addr;
        reg_wdata_i = wdata;
        reg_wstrb_i = strb;
        for (int k = 0; k < 8 && !done; k++) begin
            step(1);
            if (reg_ready_o) done = 1'b1;
        end
        rdata = reg_rdata_o;
        err   = reg_error_o;
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
        if (!done) chk("bus_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] rd;
    logic        er;
    bit          held;

    initial begin
        rst_i = 1'b1;
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
        reg_addr_i  = '0;
        reg_wdata_i = '0;
        reg_wstrb_i = '0;
        cluster_idle_i = 5'h1F;
        step(3);
        rst_i = 1'b0;

        chk("rst_ready", {31'd0, reg_ready_o}, 32'd0);
        chk("rst_clk_en", {27'd0, cluster_clk_en_o}, 32'd0);
        chk("rst_rst_n", {27'd0, cluster_rst_no}, 32'd0);
        chk("rst_iso", {27'd0, cluster_iso_o}, 32'h1F);
        chk("rst_boot0", cluster_boot_addr_o[31:0], 32'h3000_0000);
        chk("rst_boot4", cluster_boot_addr_o[159:128], 32'h3000_0000);

        // Power up cluster 0; task returns in t+1
        bus(1'b1, 32'h3000_1000, 32'h1, 4'hF, rd, er);
        chk("wr_en_err", {31'd0, er}, 32'd0);
        chk("clk_en_t1", {31'd0, cluster_clk_en_o[0]}, 32'd0);
        step(1);
        chk("clk_en_t2", {31'd0, cluster_clk_en_o[0]}, 32'd1);
        chk("rst_n_t2", {31'd0, cluster_rst_no[0]}, 32'd0);
        chk("ready_1cyc", {31'd0, reg_ready_o}, 32'd0);
        step(3);
        chk("rst_n_t5", {31'd0, cluster_rst_no[0]}, 32'd0);
        step(1);
        chk("rst_n_t6", {31'd0, cluster_rst_no[0]}, 32'd1);
        chk("iso_t6", {31'd0, cluster_iso_o[0]}, 32'd1);
        bus(1'b0, 32'h3000_1004, 32'h0, 4'h0, rd, er);
        chk("status_mid", rd, 32'h0001_0000);
        step(1);
        chk("iso_t9", {31'd0, cluster_iso_o[0]}, 32'd1);
        step(1);
        chk("iso_t10", {31'd0, cluster_iso_o[0]}, 32'd0);
        bus(1'b0, 32'h3000_1004, 32'h0, 4'h0, rd, er);
        chk("status_on", rd, 32'h0000_0001);

        // Disable while cluster is busy: stays in DRAIN
        cluster_idle_i[0] = 1'b0;
        bus(1'b1, 32'h3000_1000, 32'h0, 4'hF, rd, er);
        step(2);
        held = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (!(cluster_iso_o[0] && cluster_rst_no[0] && cluster_clk_en_o[0])) held = 1'b0;
            step(1);
        end
        chk("drain_hold", {31'd0, held}, 32'd1);
        bus(1'b0, 32'h3000_1004, 32'h0, 4'h0, rd, er);
        chk("status_drain", rd, 32'h0001_0000);
        cluster_idle_i[0] = 1'b1;
        step(1);
        chk("rstassert_u1", {29'd0, cluster_rst_no[0], cluster_clk_en_o[0], cluster_iso_o[0]}, 32'b011);
        step(3);
        chk("rstassert_u4", {29'd0, cluster_rst_no[0], cluster_clk_en_o[0], cluster_iso_o[0]}, 32'b011);
        step(1);
        chk("off_u5", {29'd0, cluster_rst_no[0], cluster_clk_en_o[0], cluster_iso_o[0]}, 32'b001);

        // Abort drain by re-enabling
        bus(1'b1, 32'h3000_1000, 32'h1, 4'hF, rd, er);
        step(12);
        chk("on_again", {31'd0, cluster_iso_o[0]}, 32'd0);
        cluster_idle_i[0] = 1'b0;
        watch_rst = 1'b1;
        bus(1'b1, 32'h3000_1000, 32'h0, 4'hF, rd, er);
        step(4);
        chk("drain_iso", {31'd0, cluster_iso_o[0]}, 32'd1);
        bus(1'b1, 32'h3000_1000, 32'h1, 4'hF, rd, er);
        chk("abort_iso_pre", {31'd0, cluster_iso_o[0]}, 32'd1);
        step(1);
        chk("abort_iso", {31'd0, cluster_iso_o[0]}, 32'd0);
        step(2);
        watch_rst = 1'b0;
        chk("abort_rst_kept", {31'd0, rst_dropped}, 32'd0);
        cluster_idle_i[0] = 1'b1;

        // Byte-strobed boot address
        bus(1'b1, 32'h3000_1018, 32'hDEAD_BEEF, 4'b0011, rd, er);
        chk("boot_wr_err", {31'd0, er}, 32'd0);
        chk("boot_wr_rdata", rd, 32'd0);
        chk("boot2_out", cluster_boot_addr_o[95:64], 32'h3000_BEEF);
        bus(1'b0, 32'h3000_1018, 32'h0, 4'h0, rd, er);
        chk("boot2_rd", rd, 32'h3000_BEEF);
        chk("boot1_out", cluster_boot_addr_o[63:32], 32'h3000_0000);

        // Error decode
        bus(1'b0, 32'h3000_1008, 32'h0, 4'h0, rd, er);
        chk("err_008", {er, rd[30:0]}, 32'h8000_0000);
        bus(1'b1, 32'h3000_1004, 32'hFFFF_FFFF, 4'hF, rd, er);
        chk("err_wr_004", {er, rd[30:0]}, 32'h8000_0000);
        bus(1'b0, 32'h3000_1024, 32'h0, 4'h0, rd, er);
        chk("err_024", {er, rd[30:0]}, 32'h8000_0000);
        bus(1'b1, 32'h3000_1012, 32'hFFFF_FFFF, 4'hF, rd, er);
        chk("err_012", {er, rd[30:0]}, 32'h8000_0000);
        chk("err_012_nochange", cluster_boot_addr_o[63:32], 32'h3000_0000);
        bus(1'b1, 32'h3000_1000, 32'h0, 4'h0, rd, er);
        chk("wstrb0_err", {31'd0, er}, 32'd0);
        bus(1'b0, 32'h3000_1000, 32'h0, 4'h0, rd, er);
        chk("en_unchanged", rd, 32'h1);
        bus(1'b0, 32'h3000_1004, 32'h0, 4'h0, rd, er);
        chk("status_unchanged", rd, 32'h1);

        // Reset during RST_REL of cluster 3
        bus(1'b1, 32'h3000_1000, 32'h9, 4'hF, rd, er);
        step(5);
        chk("c3_rst_rel", {30'd0, cluster_rst_no[3], cluster_iso_o[3]}, 32'b11);
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        chk("mid_rst_clk_en", {27'd0, cluster_clk_en_o}, 32'd0);
        chk("mid_rst_rst_n", {27'd0, cluster_rst_no}, 32'd0);
        chk("mid_rst_iso", {27'd0, cluster_iso_o}, 32'h1F);
        chk("mid_rst_boot2", cluster_boot_addr_o[95:64], 32'h3000_0000);
        bus(1'b0, 32'h3000_1000, 32'h0, 4'h0, rd, er);
        chk("mid_rst_en", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
